// File: rtl/player_input_ctrl_pkg.sv
// rtl/player_input_ctrl_pkg.sv - shared constants, FSM encoding and priority helper
package player_input_ctrl_pkg;

    localparam int NUM_PLAYERS             = 4;
    localparam int PLAYER_W                = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_RELEASE = 2'd2
    } ctrl_state_t;

    // Player 0 has the highest priority when several rise together.
    function automatic logic [PLAYER_W-1:0] lowest_index(input logic [NUM_PLAYERS-1:0] v);
        logic [PLAYER_W-1:0] idx;
        idx = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (v[i]) idx = i[PLAYER_W-1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/player_input_ctrl_debounce.sv
// rtl/player_input_ctrl_debounce.sv - 2-FF synchronizer plus counter debounce for one button
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_db
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_db;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_db    <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == LP_LAST) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/player_input_ctrl.sv
// rtl/player_input_ctrl.sv - debounced first-press arbitration with ack/re-arm for the input words
module player_input_ctrl
    import player_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PLAYERS-1:0] btn,
    input  logic [7:0]          sw,
    input  logic                ack,
    output logic                playerInputFlag,
    output logic [PLAYER_W-1:0] firstPlayerFlag,
    output logic                allButtons,
    output logic [7:0]          switchInput
);

    logic [NUM_PLAYERS-1:0] w_db;
    logic [NUM_PLAYERS-1:0] w_rise;
    logic [NUM_PLAYERS-1:0] r_db_q;
    logic [7:0]             r_sw_s1;
    logic [7:0]             r_sw_s2;
    ctrl_state_t            r_state;
    logic                   r_flag;
    logic [PLAYER_W-1:0]    r_first;
    logic                   r_all;
    logic [7:0]             r_sw_cap;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_db
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .i_btn(btn[g]),
            .o_db (w_db[g])
        );
    end

    assign w_rise = w_db & ~r_db_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db_q   <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_state  <= ST_ARMED;
            r_flag   <= 1'b0;
            r_first  <= '0;
            r_all    <= 1'b0;
            r_sw_cap <= '0;
        end else begin
            r_db_q  <= w_db;
            r_sw_s1 <= sw;
            r_sw_s2 <= r_sw_s1;
            r_all   <= &w_db;
            case (r_state)
                ST_ARMED: begin
                    if (|w_rise) begin
                        r_state  <= ST_LOCKED;
                        r_flag   <= 1'b1;
                        r_first  <= lowest_index(w_rise);
                        r_sw_cap <= r_sw_s2;
                    end
                end
                ST_LOCKED: begin
                    if (ack) begin
                        r_flag  <= 1'b0;
                        r_state <= ST_RELEASE;
                    end
                end
                // Held buttons must drop before re-arming so they cannot retrigger.
                ST_RELEASE: begin
                    if (w_db == '0) r_state <= ST_ARMED;
                end
                default: r_state <= ST_ARMED;
            endcase
        end
    end

    assign playerInputFlag = r_flag;
    assign firstPlayerFlag = r_first;
    assign allButtons      = r_all;
    assign switchInput     = r_sw_cap;

endmodule

// File: tb/tb_player_input_ctrl.sv
// tb/tb_player_input_ctrl.sv - directed self-checking bench for player_input_ctrl
module tb_player_input_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn = 4'h0;
    logic [7:0] sw  = 8'h00;
    logic       ack = 1'b0;
    logic       playerInputFlag;
    logic [1:0] firstPlayerFlag;
    logic       allButtons;
    logic [7:0] switchInput;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    player_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn            (btn),
        .sw             (sw),
        .ack            (ack),
        .playerInputFlag(playerInputFlag),
        .firstPlayerFlag(firstPlayerFlag),
        .allButtons     (allButtons),
        .switchInput    (switchInput)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outs(input string name, input logic f, input logic [1:0] idx,
                              input logic all, input logic [7:0] swv);
        checks++;
        if ({playerInputFlag, firstPlayerFlag, allButtons, switchInput} !== {f, idx, all, swv}) begin
            errors++;
            $display("FAIL %s: got flag=%b idx=%0d all=%b sw=%h, expected flag=%b idx=%0d all=%b sw=%h",
                     name, playerInputFlag, firstPlayerFlag, allButtons, switchInput, f, idx, all, swv);
        end
    endtask

    task automatic check_flag(input string name, input logic f);
        checks++;
        if (playerInputFlag !== f) begin
            errors++;
            $display("FAIL %s: got flag=%b, expected %b", name, playerInputFlag, f);
        end
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        rst = 1'b0; btn = 4'hF; sw = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if ({playerInputFlag, firstPlayerFlag, allButtons, switchInput} !== 12'h000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_hold: %0d cycles with nonzero outputs, expected 0", bad);
        end
        btn = 4'h0; rst = 1'b1;
        tick(10);
        check_outs("reset_release", 1'b0, 2'd0, 1'b0, 8'h00);
    endtask

    task automatic test_single_press();
        sw = 8'hA5; btn = 4'b0100;
        tick(6);
        check_flag("single_before_edge6", 1'b0);
        tick(1);
        check_outs("single_after_edge6", 1'b1, 2'd2, 1'b0, 8'hA5);
        pulse_ack();
        btn = 4'h0;
        tick(12);
        check_flag("single_after_ack", 1'b0);
        btn = 4'b0010;
        tick(3);
        btn = 4'h0;
        tick(12);
        check_flag("glitch_no_flag", 1'b0);
    endtask

    task automatic test_priority();
        btn = 4'b1010;
        tick(7);
        check_outs("priority_1_over_3", 1'b1, 2'd1, 1'b0, 8'hA5);
        sw = 8'h3C; btn = 4'b1011;
        tick(10);
        check_outs("locked_ignores_btn0", 1'b1, 2'd1, 1'b0, 8'hA5);
    endtask

    task automatic test_ack_release();
        btn = 4'b0010;
        tick(8);
        pulse_ack();
        check_outs("ack_clears_flag", 1'b0, 2'd1, 1'b0, 8'hA5);
        btn = 4'b1010;
        tick(10);
        check_flag("release_ignores_btn3", 1'b0);
        btn = 4'h0;
        tick(12);
        btn = 4'b1000;
        tick(6);
        check_flag("rearm_before_edge6", 1'b0);
        tick(1);
        check_outs("rearm_press_btn3", 1'b1, 2'd3, 1'b0, 8'h3C);
    endtask

    task automatic test_all_buttons();
        pulse_ack();
        btn = 4'h0;
        tick(12);
        btn = 4'hF;
        tick(6);
        checks++;
        if (allButtons !== 1'b0) begin
            errors++;
            $display("FAIL all_before: got %b, expected 0", allButtons);
        end
        tick(1);
        check_outs("all_set", 1'b1, 2'd0, 1'b1, 8'h3C);
        btn = 4'b1110;
        tick(6);
        checks++;
        if (allButtons !== 1'b1) begin
            errors++;
            $display("FAIL all_hold: got %b, expected 1", allButtons);
        end
        tick(1);
        checks++;
        if (allButtons !== 1'b0) begin
            errors++;
            $display("FAIL all_clear: got %b, expected 0", allButtons);
        end
    endtask

    task automatic test_reset_mid();
        check_flag("mid_locked", 1'b1);
        #1 rst = 1'b0;
        #1 check_outs("mid_async_reset", 1'b0, 2'd0, 1'b0, 8'h00);
        btn = 4'h0;
        tick(2);
        rst = 1'b1;
        sw = 8'h5A; btn = 4'b0100;
        tick(7);
        check_outs("post_reset_press", 1'b1, 2'd2, 1'b0, 8'h5A);
    endtask

    initial begin
        tick(1);
        test_reset();
        test_single_press();
        test_priority();
        test_ack_release();
        test_all_buttons();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
